carry_propagate_adder_seq: RTL

Sequential carry-propagate adder that resolves the redundant carry/sum pair from the carry-save compressor trees into a single binary value. It sits directly downstream of the 3:2 compressor tree. Operands arrive over a valid/ready handshake; the adder walks them DIGIT_LEN bits per cycle with a registered carry, so one narrow adder replaces a full-width ripple chain. The result is held until the consumer accepts it.

---
 rtl/carry_propagate_adder_seq_if.sv | 24 ++
 rtl/carry_propagate_adder_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/carry_propagate_adder_seq_if.sv
// Handshake bundle between the compressor tree, the sequential carry-propagate
// adder and its consumer: operand pair in, resolved binary result out.
interface carry_propagate_adder_seq_if #(
  parameter int BIT_LEN = 20
);
  logic               in_valid;
  logic               in_ready;
  logic [BIT_LEN-1:0] C;
  logic [BIT_LEN-1:0] S;
  logic               out_valid;
  logic               out_ready;
  logic [BIT_LEN-1:0] sum;
  logic               carry_out;

  modport master (
    output in_valid, C, S, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, C, S, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/carry_propagate_adder_seq.sv
// Sequential carry-propagate adder: resolves a carry-save C/S pair into binary,
// DIGIT_LEN bits per cycle through one narrow adder and a registered carry.
module carry_propagate_adder_seq #(
  parameter int BIT_LEN   = 20,
  parameter int DIGIT_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  carry_propagate_adder_seq_if.slave  bus
);
  localparam int NUM_DIGITS = (BIT_LEN + DIGIT_LEN - 1) / DIGIT_LEN;
  localparam int PAD_LEN    = NUM_DIGITS * DIGIT_LEN;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [PAD_LEN-1:0] c_reg_r;
  logic [PAD_LEN-1:0] s_reg_r;
  logic [PAD_LEN-1:0] res_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               out_valid_r;
  logic [BIT_LEN-1:0] sum_r;
  logic               carry_out_r;

  logic               in_ready_s;
  logic               accept_s;
  logic [PAD_LEN-1:0] c_pad_s;
  logic [PAD_LEN-1:0] s_pad_s;
  logic [DIGIT_LEN:0] dsum_s;
  logic [PAD_LEN-1:0] next_res_s;
  logic               final_co_s;

  assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // Zero-extend operands and form the current digit plus the shifted result.
  always_comb begin
    c_pad_s = '0;
    s_pad_s = '0;
    c_pad_s[BIT_LEN-1:0] = bus.C;
    s_pad_s[BIT_LEN-1:0] = bus.S;
    dsum_s = {1'b0, c_reg_r[DIGIT_LEN-1:0]}
           + {1'b0, s_reg_r[DIGIT_LEN-1:0]}
           + {{DIGIT_LEN{1'b0}}, carry_r};
    next_res_s = res_r >> DIGIT_LEN;
    next_res_s[PAD_LEN-1 -: DIGIT_LEN] = dsum_s[DIGIT_LEN-1:0];
  end

  // With padding, bit BIT_LEN of the result is the exact carry; without it, the last digit carry is.
  generate
    if (PAD_LEN > BIT_LEN) begin : g_pad_co
      assign final_co_s = next_res_s[BIT_LEN];
    end else begin : g_carry_co
      assign final_co_s = dsum_s[DIGIT_LEN];
    end
  endgenerate

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      c_reg_r     <= '0;
      s_reg_r     <= '0;
      res_r       <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            c_reg_r <= c_pad_s;
            s_reg_r <= s_pad_s;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            state_r <= ADD;
          end else begin
            state_r <= IDLE;
          end
        end
        ADD: begin
          c_reg_r <= c_reg_r >> DIGIT_LEN;
          s_reg_r <= s_reg_r >> DIGIT_LEN;
          res_r   <= next_res_s;
          carry_r <= dsum_s[DIGIT_LEN];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            sum_r       <= next_res_s[BIT_LEN-1:0];
            carry_out_r <= final_co_s;
          end else begin
            state_r <= ADD;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.in_valid) begin
              c_reg_r <= c_pad_s;
              s_reg_r <= s_pad_s;
              carry_r <= 1'b0;
              cnt_r   <= '0;
              state_r <= ADD;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_out_r;
endmodule
